serial_adder: RTL and testbench

Parametrised multi-cycle adder: the sequential successor to the single-bit full adder. It adds two WIDTH-bit operands plus carry-in DIGIT bits per clock, using a registered carry between steps. A start/busy/done handshake lets it sit as an area-cheap arithmetic unit behind a simple controller. Width and throughput are traded through parameters.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_slice.sv | 24 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and sizing helpers.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 0 : width / digit;
  endfunction

  // One spare bit so the counter can represent STEPS itself.
  function automatic int unsigned calc_cnt_w(input int unsigned steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// DIGIT-bit combinational ripple of full-adder cells.
module adder_slice #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[DIGIT];
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per clock with a
// registered carry and a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STEPS = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(STEPS);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, psum, psum_nx;
  logic             carry;
  logic [DIGIT-1:0] s_slice;
  logic             co_slice;
  logic             accept;
  logic             last;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x  (ra[DIGIT-1:0]),
    .y  (rb[DIGIT-1:0]),
    .ci (carry),
    .s  (s_slice),
    .co (co_slice)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = (cnt == CNT_W'(STEPS - 1));
    // New digit enters at the top; shift expressed without slices so STEPS=1 works.
    psum_nx  = (psum >> DIGIT) | (WIDTH'(s_slice) << (WIDTH - DIGIT));
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> DIGIT;
      rb    <= rb >> DIGIT;
      carry <= co_slice;
      psum  <= psum_nx;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= psum_nx;
        cout <= co_slice;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at three parameter points (8/1, 16/4, 4/2).
module tb_serial_adder;

  typedef struct {
    logic [16:0] res;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       st8, ci8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic        st16, ci16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic       st4, ci4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q8[$], q16[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );
  serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop expected result and completion cycle on every done pulse.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      chk("busy8_with_done", 32'(busy8), 32'd0);
      if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("res8", 32'({cout8, sum8}), 32'(e.res));
        chk("lat8", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      chk("busy16_with_done", 32'(busy16), 32'd0);
      if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        chk("res16", 32'({cout16, sum16}), 32'(e.res));
        chk("lat16", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      chk("busy4_with_done", 32'(busy4), 32'd0);
      if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("res4", 32'({cout4, sum4}), 32'(e.res));
        chk("lat4", cyc, e.due);
      end
    end
  end

  // Each go task asserts start, pushes the expectation at the accepting edge,
  // then scrambles the operands to show they are not re-sampled.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [16:0] res);
    a8 = a; b8 = b; ci8 = c; st8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back('{res: res, due: cyc + 8});
    st8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~c;
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] res);
    a16 = a; b16 = b; ci16 = c; st16 = 1'b1;
    @(posedge clk); #1;
    q16.push_back('{res: res, due: cyc + 4});
    st16 = 1'b0; a16 = ~a; b16 = ~b; ci16 = ~c;
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [16:0] res);
    a4 = a; b4 = b; ci4 = c; st4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{res: res, due: cyc + 2});
    st4 = 1'b0; a4 = ~a; b4 = ~b; ci4 = ~c;
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
  endtask
  task automatic wait_done16();
    for (int i = 0; i < 40 && !done16; i++) @(negedge clk);
  endtask
  task automatic wait_done4();
    for (int i = 0; i < 40 && !done4; i++) @(negedge clk);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    st8 = 0; a8 = '0; b8 = '0; ci8 = 0;
    st16 = 0; a16 = '0; b16 = '0; ci16 = 0;
    st4 = 0; a4 = '0; b4 = '0; ci4 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_res8", 32'({cout8, sum8}), 32'd0);
    chk("rst_res16", 32'({cout16, sum16}), 32'd0);
    chk("rst_res4", 32'({cout4, sum4}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xFF + 0x01: full carry ripple, busy exactly 8 cycles
    go8(8'hFF, 8'h01, 1'b0, 17'h100);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8) n++;
    end
    chk("busy8_cycles", 32'(n), 32'd8);

    // Back-to-back: second start issued during DONE
    go8(8'hA5, 8'h5A, 1'b1, 17'h100);
    wait_done8();
    go8(8'h12, 8'h34, 1'b0, 17'h046);
    chk("b2b_busy8", 32'(busy8), 32'd1);
    chk("b2b_done8", 32'(done8), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("sum8_hold", 32'({cout8, sum8}), 32'h100);
    wait_done8();

    // WIDTH=16, DIGIT=4
    @(negedge clk);
    go16(16'h1234, 16'hEDCB, 1'b1, 17'h10000);
    wait_done16();
    @(negedge clk);
    go16(16'h0001, 16'h0002, 1'b0, 17'h00003);
    wait_done16();

    // WIDTH=4, DIGIT=2 exhaustive
    @(negedge clk);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          go4(4'(a), 4'(b), 1'(c), 17'(a + b + c));
          wait_done4();
        end

    // start during RUN ignored
    @(negedge clk);
    go8(8'h80, 8'h80, 1'b0, 17'h100);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait_done8();

    // Asynchronous reset mid-RUN aborts the operation
    @(negedge clk);
    go8(8'h55, 8'h11, 1'b0, 17'h066);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy8", 32'(busy8), 32'd0);
    chk("arst_done8", 32'(done8), 32'd0);
    chk("arst_res8", 32'({cout8, sum8}), 32'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    go8(8'h03, 8'h04, 1'b0, 17'h007);
    wait_done8();

    repeat (3) @(negedge clk);
    chk("pending8", 32'(q8.size()), 32'd0);
    chk("pending16", 32'(q16.size()), 32'd0);
    chk("pending4", 32'(q4.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
